bitmap_vram_ctrl: RTL
=====================

Name: bitmap_vram_ctrl

Overview:
- Parametrised bitmap frame-buffer controller: single-port inferred synchronous RAM, arbitrated between a CPU read/write port and a video pixel fetch/shift pipeline.
- Successor to the fixed 4x4416 bitmap RAM. Adds configurable pixel width, pixels per word and depth, a req/ack CPU handshake, per-pixel write masking, flipped readout and underrun detection.
- Sits between the CPU bus decoder and the video mixer.

Parameters:
ADDR_W, 14, word address width; depth = 2**ADDR_W words
PIX_W, 4, bits per pixel
PIX_PER_WORD, 4, pixels per RAM word; WORD_W = PIX_W*PIX_PER_WORD

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
cpu_req  in  1  transaction request; addr, data and mask held stable until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  word address
cpu_din  in  WORD_W  write data
cpu_wmask  in  PIX_PER_WORD  per-pixel write enable; bit k covers pixel k = din[k*PIX_W +: PIX_W]
cpu_ack  out  1  one-cycle completion pulse
cpu_dout  out  WORD_W  read data; valid while cpu_ack=1 after a read, held until the next read completes
vid_start  in  1  line start pulse; latches vid_addr and vid_flip
vid_addr  in  ADDR_W  first word of the line
vid_flip  in  1  1 = reverse pixel order and decrement address
vid_ce  in  1  pixel clock enable; asserted at most every 2nd clk
pix_out  out  PIX_W  current pixel
underrun  out  1  sticky; set when a pixel is needed and none is buffered
clr_start  in  1  clear-engine start (see Optional Feature)
clr_busy  out  1  clear engine active

Behaviour:
- Reset: cpu_ack=0, cpu_dout=0, pix_out=0, underrun=0, clr_busy=0. CPU FSM goes to IDLE; video buffers are emptied and no fetch is pending. A transaction in flight is dropped without ack. RAM contents are not cleared.
- RAM: one access per clk, 1-cycle read latency.
- Arbitration per cycle:
  - 1st: video fetch, when fetch_pend=1.
  - 2nd: clear engine.
  - 3rd: CPU, when the FSM is in IDLE and cpu_req=1.
  - A denied CPU request stays in IDLE and retries the next cycle.
- CPU FSM states: IDLE, RD, ACK.
  - Write granted in cycle T: masked write in T, state ACK at T+1 with cpu_ack=1, then IDLE.
  - Read granted in cycle T: RD at T+1, where the RAM word is captured into cpu_dout. ACK at T+2.
  - No grant occurs in the ACK cycle. The requester must drop cpu_req in the cycle after cpu_ack, otherwise a new transaction starts.
- Write mask: pixel k of the RAM word is updated only if cpu_wmask[k]=1. A mask of 0 completes and acks with no change.
- Video pipeline: shift word sh, remaining count cnt (0..PIX_PER_WORD), prefetch buffer pf with pf_valid, fetch address fa.
  - vid_start (priority over all video activity that cycle): fa <= vid_addr; flip_r <= vid_flip; cnt=0; pf_valid=0; fetch_pend=1; pix_out unchanged.
  - Fetch: granted in cycle T, pf is loaded at T+1 and pf_valid=1. fa <= fa+1, or fa-1 if flip_r, modulo 2**ADDR_W (wraps 0 <-> max). fetch_pend=0.
  - Reload: when cnt=0, pf_valid=1 and vid_ce=0, then sh <= pf, cnt=PIX_PER_WORD, pf_valid=0, fetch_pend=1.
  - vid_ce with cnt>0: pix_out <= pixel index (PIX_PER_WORD-cnt), or (cnt-1) if flip_r; then cnt--.
  - vid_ce with cnt=0: pix_out <= 0 and underrun <= 1.
  - underrun clears only on reset or vid_start.
- Line lead time: vid_start must precede the first vid_ce by at least 4 clks.

Optional Feature:
VRAM_CLEAR_EN:
- Defined: clr_start (ignored while busy) sets clr_busy=1 and a clear counter to 0. Each cycle not used by video writes 0 to all pixels at the counter address, then increments. clr_busy drops the cycle after address 2**ADDR_W-1 is written. The CPU is never granted while clr_busy=1. reset aborts the clear.
- Undefined: clr_start is ignored and clr_busy is tied to 0; no clear logic is present.

Test Plan:
- CPU write 0x1234 to addr 5 with mask 4'b1111; read addr 5 -> cpu_ack at T+1 for the write; read ack at T+2 with cpu_dout=0x1234.
- Addr 5 holds 0x1234; write 0xABCD with mask 4'b0101 -> read returns 0x1B3D.
- Preload words 0x3210 and 0x7654 at addr 0,1; vid_start addr 0, flip=0; vid_ce every 4 clks -> pix_out 0,1,2,3,4,5,6,7; underrun=0.
- Same data; vid_start addr 1, flip=1 -> pix_out 7,6,5,4,3,2,1,0. Then fa wraps to 2**ADDR_W-1 with no error.
- CPU reads issued continuously during an active line -> all pixels correct, every read acked with the correct data.
- vid_ce asserted every 2 clks with vid_start only 1 clk earlier -> first pix_out=0, underrun=1. A later vid_start clears it.

Source files
------------

// File: rtl/bitmap_vram_ctrl_if.sv
// CPU-side request/acknowledge bus of the bitmap frame-buffer controller.
// The CPU drives through the master modport; the controller uses the slave modport.
interface bitmap_vram_ctrl_if #(
    parameter int ADDR_W       = 14,
    parameter int PIX_W        = 4,
    parameter int PIX_PER_WORD = 4
);
    localparam int WORD_W = PIX_W * PIX_PER_WORD;

    logic                    cpu_req;
    logic                    cpu_we;
    logic [ADDR_W-1:0]       cpu_addr;
    logic [WORD_W-1:0]       cpu_din;
    logic [PIX_PER_WORD-1:0] cpu_wmask;
    logic                    cpu_ack;
    logic [WORD_W-1:0]       cpu_dout;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din, cpu_wmask,
        input  cpu_ack, cpu_dout
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din, cpu_wmask,
        output cpu_ack, cpu_dout
    );
endinterface

// File: rtl/bitmap_vram_ctrl.sv
// Bitmap frame-buffer controller: one single-port RAM shared by video fetch, clear engine and CPU.
// Optional clear engine is built only when VRAM_CLEAR_EN is defined.
module bitmap_vram_ctrl #(
    parameter int ADDR_W       = 14,
    parameter int PIX_W        = 4,
    parameter int PIX_PER_WORD = 4
) (
    input  logic                clk,
    input  logic                reset,
    bitmap_vram_ctrl_if.slave   bus,
    input  logic                vid_start,
    input  logic [ADDR_W-1:0]   vid_addr,
    input  logic                vid_flip,
    input  logic                vid_ce,
    output logic [PIX_W-1:0]    pix_out,
    output logic                underrun,
    input  logic                clr_start,
    output logic                clr_busy
);
    localparam int WORD_W = PIX_W * PIX_PER_WORD;
    localparam int CNT_W  = $clog2(PIX_PER_WORD + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PIX_PER_WORD);

    typedef enum logic [1:0] {IDLE, RD, ACK} cpu_st_e;

    // RAM port
    logic [WORD_W-1:0]       mem [0:(1<<ADDR_W)-1];
    logic [WORD_W-1:0]       ram_rdata_q;
    logic [ADDR_W-1:0]       ram_addr;
    logic                    ram_we;
    logic [WORD_W-1:0]       ram_wdata;
    logic [PIX_PER_WORD-1:0] ram_mask;

    // CPU FSM
    cpu_st_e           st_q, st_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [WORD_W-1:0] cpu_dout_q, cpu_dout_d;

    // video pipeline
    logic [ADDR_W-1:0] fa_q, fa_d;
    logic              flip_q, flip_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [WORD_W-1:0] pf_q, pf_d;
    logic              pf_valid_q, pf_valid_d;
    logic              fetch_pend_q, fetch_pend_d;
    logic              inflight_q, inflight_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              underrun_q, underrun_d;

    logic              vid_grant, clr_grant, cpu_grant, reload;
    logic              clr_busy_w;
    logic [ADDR_W-1:0] clr_addr_w;
    logic [PIX_W-1:0]  pix_sel;
    int                pix_idx;

`ifdef VRAM_CLEAR_EN
    logic              clr_busy_q, clr_busy_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    assign clr_busy_w = clr_busy_q;
    assign clr_addr_w = clr_cnt_q;

    always_comb begin
        clr_busy_d = clr_busy_q;
        clr_cnt_d  = clr_cnt_q;
        if (!clr_busy_q) begin
            if (clr_start) begin
                clr_busy_d = 1'b1;
                clr_cnt_d  = '0;
            end
        end else if (clr_grant) begin
            if (clr_cnt_q == '1) clr_busy_d = 1'b0;
            else                 clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_busy_q <= 1'b0;
            clr_cnt_q  <= '0;
        end else begin
            clr_busy_q <= clr_busy_d;
            clr_cnt_q  <= clr_cnt_d;
        end
    end
`else
    logic unused_clr_start;
    assign unused_clr_start = clr_start;
    assign clr_busy_w       = 1'b0;
    assign clr_addr_w       = '0;
`endif

    // A line start cancels any fetch that would use the stale address.
    assign vid_grant = fetch_pend_q && !vid_start;
    assign clr_grant = clr_busy_w && !vid_grant;
    assign cpu_grant = (st_q == IDLE) && bus.cpu_req && !vid_grant && !clr_busy_w;
    assign reload    = (cnt_q == '0) && pf_valid_q && !vid_ce;

    always_comb begin
        ram_addr  = fa_q;
        ram_we    = 1'b0;
        ram_wdata = bus.cpu_din;
        ram_mask  = bus.cpu_wmask;
        if (vid_grant) begin
            ram_addr = fa_q;
        end else if (clr_grant) begin
            ram_addr  = clr_addr_w;
            ram_we    = 1'b1;
            ram_wdata = '0;
            ram_mask  = '1;
        end else if (cpu_grant) begin
            ram_addr = bus.cpu_addr;
            ram_we   = bus.cpu_we;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < PIX_PER_WORD; k++) begin
            if (ram_we && ram_mask[k])
                mem[ram_addr][k*PIX_W +: PIX_W] <= ram_wdata[k*PIX_W +: PIX_W];
        end
        ram_rdata_q <= mem[ram_addr];
    end

    always_comb begin
        st_d       = st_q;
        cpu_ack_d  = 1'b0;
        cpu_dout_d = cpu_dout_q;
        case (st_q)
            IDLE: if (cpu_grant) begin
                if (bus.cpu_we) begin
                    st_d      = ACK;
                    cpu_ack_d = 1'b1;
                end else begin
                    st_d = RD;
                end
            end
            RD: begin
                cpu_dout_d = ram_rdata_q;
                st_d       = ACK;
                cpu_ack_d  = 1'b1;
            end
            ACK:     st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    // Pixels leave in ascending order, or descending when the line is flipped.
    always_comb begin
        pix_idx = flip_q ? int'(cnt_q) - 1 : PIX_PER_WORD - int'(cnt_q);
        pix_sel = '0;
        for (int k = 0; k < PIX_PER_WORD; k++) begin
            if (k == pix_idx) pix_sel = sh_q[k*PIX_W +: PIX_W];
        end
    end

    always_comb begin
        fa_d         = fa_q;
        flip_d       = flip_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        pf_d         = pf_q;
        pf_valid_d   = pf_valid_q;
        fetch_pend_d = fetch_pend_q;
        inflight_d   = 1'b0;
        pix_d        = pix_q;
        underrun_d   = underrun_q;
        if (vid_start) begin
            fa_d         = vid_addr;
            flip_d       = vid_flip;
            cnt_d        = '0;
            pf_valid_d   = 1'b0;
            fetch_pend_d = 1'b1;
            underrun_d   = 1'b0;
        end else begin
            inflight_d = vid_grant;
            if (vid_grant) begin
                fa_d         = flip_q ? fa_q - ADDR_W'(1) : fa_q + ADDR_W'(1);
                fetch_pend_d = 1'b0;
            end
            if (inflight_q) begin
                pf_d       = ram_rdata_q;
                pf_valid_d = 1'b1;
            end
            if (reload) begin
                sh_d         = pf_q;
                cnt_d        = CNT_FULL;
                pf_valid_d   = 1'b0;
                fetch_pend_d = 1'b1;
            end else if (vid_ce) begin
                if (cnt_q != '0) begin
                    pix_d = pix_sel;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    pix_d      = '0;
                    underrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q         <= IDLE;
            cpu_ack_q    <= 1'b0;
            cpu_dout_q   <= '0;
            fa_q         <= '0;
            flip_q       <= 1'b0;
            cnt_q        <= '0;
            sh_q         <= '0;
            pf_q         <= '0;
            pf_valid_q   <= 1'b0;
            fetch_pend_q <= 1'b0;
            inflight_q   <= 1'b0;
            pix_q        <= '0;
            underrun_q   <= 1'b0;
        end else begin
            st_q         <= st_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_dout_q   <= cpu_dout_d;
            fa_q         <= fa_d;
            flip_q       <= flip_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            pf_q         <= pf_d;
            pf_valid_q   <= pf_valid_d;
            fetch_pend_q <= fetch_pend_d;
            inflight_q   <= inflight_d;
            pix_q        <= pix_d;
            underrun_q   <= underrun_d;
        end
    end

    assign bus.cpu_ack  = cpu_ack_q;
    assign bus.cpu_dout = cpu_dout_q;
    assign pix_out      = pix_q;
    assign underrun     = underrun_q;
    assign clr_busy     = clr_busy_w;
endmodule
